// File: rtl/io_stream_monitor.sv
// io_stream_monitor: multi-channel strobe capture into per-channel FIFOs, round-robin drained, with EOT/overflow/timeout flags.
// Define IO_STREAM_MONITOR_SIG_EN to build the 32-bit capture signature register on sig_o.
module io_stream_monitor #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] EOT_CHAR = DATA_W'(8'h04),
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_W = 32,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic [NUM_CH-1:0]        strobe_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CH_W-1:0]          out_ch_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [NUM_CH-1:0]        done_o,
    output logic                     all_done_o,
    output logic [NUM_CH-1:0]        overflow_o,
    output logic                     timeout_o,
    output logic [31:0]              sig_o
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [NUM_CH-1:0] strobe_q, done_q, done_d, ovf_q, ovf_d, cap, we, pop;
    logic [PTR_W-1:0]  wr_q [NUM_CH], wr_d [NUM_CH], rd_q [NUM_CH], rd_d [NUM_CH];
    logic [PTR_W:0]    fill_q [NUM_CH], fill_d [NUM_CH];
    logic [DATA_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic              out_valid_q, out_valid_d, timeout_q, timeout_d, all_done, found;
    logic [CH_W-1:0]   out_ch_q, out_ch_d, rr_q, rr_d, idx;
    logic [CH_W:0]     sum;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef IO_STREAM_MONITOR_SIG_EN
    logic [31:0]       sig_q, sig_d;
`endif

    assign cap = strobe_i & ~strobe_q & ch_en_i;

    always_comb begin
        all_done = ~out_valid_q;
        for (int c = 0; c < NUM_CH; c++)
            if (!(done_q[c] | ~ch_en_i[c]) || fill_q[c] != '0) all_done = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        rr_d        = rr_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fill_d      = fill_q;
        pop         = '0;
        we          = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
`ifdef IO_STREAM_MONITOR_SIG_EN
        sig_d       = sig_q;
`endif
        // Round-robin search starts at rr_ptr; only FIFOs non-empty before this cycle's writes qualify.
        if (~out_valid_q | out_ready_i) begin
            out_valid_d = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sum = {1'b0, rr_q} + (CH_W+1)'(i);
                if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
                idx = sum[CH_W-1:0];
                if (!found && fill_q[idx] != '0) begin
                    found       = 1'b1;
                    pop[idx]    = 1'b1;
                    out_valid_d = 1'b1;
                    out_ch_d    = idx;
                    out_data_d  = mem_q[idx][rd_q[idx]];
                    rr_d        = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            we[c] = cap[c] & ((fill_q[c] != FULL) | pop[c]);
            if (cap[c] && data_i[c*DATA_W +: DATA_W] == EOT_CHAR) done_d[c] = 1'b1;
            if (cap[c] && !we[c]) ovf_d[c] = 1'b1;
            if (we[c]) wr_d[c] = wr_q[c] + 1'b1;
            if (pop[c]) rd_d[c] = rd_q[c] + 1'b1;
            fill_d[c] = fill_q[c] + (PTR_W+1)'(we[c]) - (PTR_W+1)'(pop[c]);
`ifdef IO_STREAM_MONITOR_SIG_EN
            if (we[c]) sig_d = {sig_d[30:0], sig_d[31]} ^ {8'(c), 24'(data_i[c*DATA_W +: DATA_W])};
`endif
        end
        if (run_i && !all_done && !timeout_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_d = 1'b1;
        end
        if (clear_i) begin
            out_valid_d = 1'b0;
            out_ch_d    = '0;
            out_data_d  = '0;
            rr_d        = rr_q;
            done_d      = '0;
            ovf_d       = '0;
            cnt_d       = '0;
            timeout_d   = 1'b0;
            we          = '0;
            wr_d        = '{default: '0};
            rd_d        = '{default: '0};
            fill_d      = '{default: '0};
`ifdef IO_STREAM_MONITOR_SIG_EN
            sig_d       = '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            rr_q        <= '0;
            done_q      <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            wr_q        <= '{default: '0};
            rd_q        <= '{default: '0};
            fill_q      <= '{default: '0};
        end else begin
            strobe_q    <= strobe_i;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fill_q      <= fill_d;
        end
    end

    // Storage needs no reset: pointers and fill counts alone decide what is visible.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++)
            if (we[c]) mem_q[c][wr_q[c]] <= data_i[c*DATA_W +: DATA_W];
    end

`ifdef IO_STREAM_MONITOR_SIG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sig_q <= '0;
        else sig_q <= sig_d;
    end
    assign sig_o = sig_q;
`else
    assign sig_o = 32'h0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;
    assign done_o      = done_q;
    assign all_done_o  = all_done;
    assign overflow_o  = ovf_q;
    assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_io_stream_monitor.sv
// tb_io_stream_monitor: scenario tasks plus randomized traffic checked against a queue-based reference model.
module tb_io_stream_monitor;
    localparam int DEPTH = 16;
    localparam int TO = 100;

    logic        clock = 1'b0, reset = 1'b1, run_i = 1'b0, clear_i = 1'b0, out_ready_i = 1'b0;
    logic [1:0]  ch_en_i = 2'b11, strobe_i = 2'b00;
    logic [15:0] data_i = '0;
    logic        out_valid_o, all_done_o, timeout_o;
    logic [0:0]  out_ch_o;
    logic [7:0]  out_data_o;
    logic [1:0]  done_o, overflow_o;
    logic [31:0] sig_o;

    int pass_cnt = 0, total_cnt = 0;
    int obs[$], exq[$];

    logic [7:0]  mq[2][$];
    bit          m_ov, m_to;
    int          m_ch, m_rr, m_cnt;
    logic [7:0]  m_data;
    bit [1:0]    m_done, m_ovf, m_prev;
    logic [31:0] m_sig;

    io_stream_monitor #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .run_i(run_i), .clear_i(clear_i), .ch_en_i(ch_en_i),
        .strobe_i(strobe_i), .data_i(data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ch_o(out_ch_o), .out_data_o(out_data_o), .done_o(done_o), .all_done_o(all_done_o),
        .overflow_o(overflow_o), .timeout_o(timeout_o), .sig_o(sig_o)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_sig();
`ifdef IO_STREAM_MONITOR_SIG_EN
        return m_sig;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        mq[0].delete();
        mq[1].delete();
        m_ov = 0; m_to = 0; m_ch = 0; m_rr = 0; m_cnt = 0; m_data = 0;
        m_done = 0; m_ovf = 0; m_prev = 0; m_sig = 0;
    endtask

    // One clock of the monitor described in terms of byte queues.
    task automatic model_step();
        int win;
        bit ad;
        bit acc[2];
        logic [7:0] d;
        win = -1;
        ad = !m_ov && mq[0].size() == 0 && mq[1].size() == 0;
        for (int c = 0; c < 2; c++) if (!m_done[c] && ch_en_i[c]) ad = 0;
        if (clear_i) begin
            mq[0].delete(); mq[1].delete();
            m_ov = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_to = 0; m_sig = 0;
            m_prev = strobe_i;
            return;
        end
        if (!m_ov || out_ready_i)
            for (int i = 0; i < 2; i++) if (win < 0 && mq[(m_rr + i) % 2].size() > 0) win = (m_rr + i) % 2;
        for (int c = 0; c < 2; c++) begin
            acc[c] = 0;
            if (strobe_i[c] && !m_prev[c] && ch_en_i[c]) begin
                d = data_i[c*8 +: 8];
                if (d == 8'h04) m_done[c] = 1;
                if (mq[c].size() < DEPTH || win == c) acc[c] = 1;
                else m_ovf[c] = 1;
            end
        end
        if (!m_ov || out_ready_i) begin
            m_ov = (win >= 0);
            if (win >= 0) begin
                m_ch = win;
                m_data = mq[win].pop_front();
                m_rr = (win + 1) % 2;
            end
        end
        for (int c = 0; c < 2; c++) if (acc[c]) begin
            d = data_i[c*8 +: 8];
            mq[c].push_back(d);
            m_sig = {m_sig[30:0], m_sig[31]} ^ ((32'(c) << 24) | 32'(d));
        end
        if (run_i && !ad && !m_to) begin
            if (m_cnt == TO - 1) m_to = 1;
            m_cnt++;
        end
        m_prev = strobe_i;
    endtask

    task automatic tick();
        if (out_valid_o && out_ready_i) obs.push_back(int'(out_ch_o) * 256 + int'(out_data_o));
        if (m_ov && out_ready_i) exq.push_back(m_ch * 256 + int'(m_data));
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d0, input logic [7:0] d1, input int gap);
        strobe_i = s;
        data_i = {d1, d0};
        tick();
        strobe_i = 2'b00;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset = 1; strobe_i = 0; clear_i = 0; run_i = 0; data_i = 0; out_ready_i = 0;
        @(posedge clock);
        #1;
        model_reset();
        obs.delete();
        exq.delete();
        reset = 0;
    endtask

    task automatic test_reset();
        ch_en_i = 2'b11;
        do_reset();
        total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid_o); else pass_cnt++;
        total_cnt++; if ({done_o, overflow_o} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {done_o, overflow_o}); else pass_cnt++;
        total_cnt++; if ({timeout_o, all_done_o} !== 2'b0) $display("FAIL reset_to_alldone got %b exp 00", {timeout_o, all_done_o}); else pass_cnt++;
        total_cnt++; if (sig_o !== 32'h0) $display("FAIL reset_sig got %h exp 0", sig_o); else pass_cnt++;
    endtask

    task automatic test_eot();
        logic [7:0] exp_b[4] = '{8'h4F, 8'h4B, 8'h0A, 8'h04};
        int errs = 0;
        do_reset();
        ch_en_i = 2'b01;
        out_ready_i = 1;
        for (int i = 0; i < 4; i++) send(2'b01, exp_b[i], 8'h00, 3);
        repeat (3) tick();
        total_cnt++; if (obs.size() !== 4) $display("FAIL eot_count got %0d exp 4", obs.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < obs.size(); i++) if (obs[i] !== int'(exp_b[i])) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL eot_bytes got %0d wrong beats exp 0", errs); else pass_cnt++;
        total_cnt++; if (done_o !== 2'b01) $display("FAIL eot_done got %b exp 01", done_o); else pass_cnt++;
        total_cnt++; if (all_done_o !== 1'b1) $display("FAIL eot_all_done got %b exp 1", all_done_o); else pass_cnt++;
        total_cnt++; if (overflow_o !== 2'b00) $display("FAIL eot_overflow got %b exp 00", overflow_o); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int errs = 0;
        do_reset();
        ch_en_i = 2'b11;
        out_ready_i = 1;
        for (int i = 0; i < 4; i++) send(2'b11, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1);
        repeat (4) tick();
        total_cnt++; if (obs.size() !== 8) $display("FAIL rr_count got %0d exp 8", obs.size()); else pass_cnt++;
        for (int i = 0; i < 8 && i < obs.size(); i++)
            if (obs[i] !== ((i % 2 == 0) ? 8'hA0 + i / 2 : 256 + 8'hB0 + i / 2)) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL rr_order got %0d wrong beats exp 0", errs); else pass_cnt++;
        total_cnt++; if (obs !== exq) $display("FAIL rr_model got %0d beats exp %0d", obs.size(), exq.size()); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int errs = 0;
        do_reset();
        ch_en_i = 2'b10;
        for (int i = 0; i < 20; i++) send(2'b10, 8'h00, 8'h10 + 8'(i), 1);
        total_cnt++; if (overflow_o !== 2'b10) $display("FAIL ovf_flag got %b exp 10", overflow_o); else pass_cnt++;
        out_ready_i = 1;
        repeat (25) tick();
        // the output register holds one byte ahead of the 16-entry FIFO
        total_cnt++; if (obs.size() !== DEPTH + 1) $display("FAIL ovf_count got %0d exp %0d", obs.size(), DEPTH + 1); else pass_cnt++;
        for (int i = 0; i < obs.size(); i++) if (obs[i] !== 256 + 8'h10 + i) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL ovf_order got %0d wrong beats exp 0", errs); else pass_cnt++;
        total_cnt++; if (obs !== exq) $display("FAIL ovf_model got %0d beats exp %0d", obs.size(), exq.size()); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        do_reset();
        ch_en_i = 2'b10;
        for (int i = 0; i < 17; i++) send(2'b10, 8'h00, 8'h20 + 8'(i), 1);
        total_cnt++; if ({out_valid_o, overflow_o} !== 3'b100) $display("FAIL fullpop_pre got %b exp 100", {out_valid_o, overflow_o}); else pass_cnt++;
        out_ready_i = 1;
        send(2'b10, 8'h00, 8'h77, 0);
        total_cnt++; if (overflow_o !== 2'b00) $display("FAIL fullpop_ovf got %b exp 00", overflow_o); else pass_cnt++;
        repeat (25) tick();
        total_cnt++; if (obs.size() !== 18) $display("FAIL fullpop_count got %0d exp 18", obs.size()); else pass_cnt++;
        total_cnt++; if (obs.size() == 0 || obs[obs.size() - 1] !== 256 + 8'h77) $display("FAIL fullpop_last got %0d beats exp last 0x177", obs.size()); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        ch_en_i = 2'b11;
        out_ready_i = 1;
        run_i = 1;
        while (!timeout_o && n < 300) begin tick(); n++; end
        total_cnt++; if (n !== TO) $display("FAIL timeout_cycles got %0d exp %0d", n, TO); else pass_cnt++;
        total_cnt++; if (timeout_o !== m_to) $display("FAIL timeout_model got %b exp %b", timeout_o, m_to); else pass_cnt++;
        run_i = 0;
        clear_i = 1;
        tick();
        clear_i = 0;
        total_cnt++; if (timeout_o !== 1'b0) $display("FAIL timeout_clear got %b exp 0", timeout_o); else pass_cnt++;
        run_i = 1; repeat (50) tick();
        run_i = 0; repeat (10) tick();
        total_cnt++; if (timeout_o !== 1'b0) $display("FAIL timeout_paused got %b exp 0", timeout_o); else pass_cnt++;
        run_i = 1;
        n = 60;
        while (!timeout_o && n < 400) begin tick(); n++; end
        total_cnt++; if (n !== TO + 10) $display("FAIL timeout_delayed got %0d exp %0d", n, TO + 10); else pass_cnt++;
        run_i = 0;
    endtask

    task automatic test_sig();
        logic [31:0] e1;
`ifdef IO_STREAM_MONITOR_SIG_EN
        e1 = 32'h1;
`else
        e1 = 32'h0;
`endif
        do_reset();
        ch_en_i = 2'b01;
        out_ready_i = 1;
        send(2'b01, 8'h01, 8'h00, 1);
        total_cnt++; if (sig_o !== e1) $display("FAIL sig_first got %h exp %h", sig_o, e1); else pass_cnt++;
        send(2'b01, 8'h02, 8'h00, 1);
        total_cnt++; if (sig_o !== 32'h0) $display("FAIL sig_second got %h exp 0", sig_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int v = 0;
        do_reset();
        ch_en_i = 2'b01;
        for (int i = 0; i < 5; i++) send(2'b01, 8'h04 + 8'(i), 8'h00, 1);
        total_cnt++; if ({out_valid_o, done_o} !== 3'b101) $display("FAIL midrst_pre got %b exp 101", {out_valid_o, done_o}); else pass_cnt++;
        #2 reset = 1;
        #1;
        total_cnt++; if ({out_valid_o, out_data_o, done_o, overflow_o, timeout_o} !== 14'b0) $display("FAIL midrst_async got %h exp 0", {out_valid_o, out_data_o, done_o, overflow_o, timeout_o}); else pass_cnt++;
        @(posedge clock);
        #1;
        reset = 0;
        model_reset();
        obs.delete();
        exq.delete();
        out_ready_i = 1;
        repeat (6) begin tick(); if (out_valid_o) v++; end
        total_cnt++; if (v !== 0 || obs.size() !== 0) $display("FAIL midrst_leftover got %0d valid cycles exp 0", v); else pass_cnt++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        ch_en_i = 2'b11;
        for (int i = 0; i < 400; i++) begin
            strobe_i = 2'($urandom);
            data_i = 16'($urandom);
            out_ready_i = ($urandom_range(0, 9) < 7);
            clear_i = ($urandom_range(0, 99) == 0);
            run_i = 1'($urandom);
            tick();
        end
        clear_i = 0; strobe_i = 0; run_i = 0; out_ready_i = 1;
        repeat (40) tick();
        total_cnt++; if (obs.size() !== exq.size()) $display("FAIL rand_count got %0d exp %0d", obs.size(), exq.size()); else pass_cnt++;
        for (int i = 0; i < obs.size() && i < exq.size(); i++) if (obs[i] !== exq[i]) errs++;
        total_cnt++; if (errs !== 0) $display("FAIL rand_stream got %0d wrong beats exp 0", errs); else pass_cnt++;
        total_cnt++; if ({done_o, overflow_o} !== {m_done, m_ovf}) $display("FAIL rand_flags got %b exp %b", {done_o, overflow_o}, {m_done, m_ovf}); else pass_cnt++;
        total_cnt++; if (sig_o !== exp_sig()) $display("FAIL rand_sig got %h exp %h", sig_o, exp_sig()); else pass_cnt++;
        total_cnt++; if (timeout_o !== m_to) $display("FAIL rand_timeout got %b exp %b", timeout_o, m_to); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_eot();
        test_round_robin();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_sig();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
